sdcard_apb_arbiter: RTL

//  Shares the single APB slave port of the SD-card controller between two requesters:
//  m0 (CPU peripheral bus) and m1 (boot/DMA sector sequencer). Registered downstream
//  APB master; round-robin or fixed priority; optional lock keeps multi-register

---
 rtl/sd_pkg.sv | 15 +
 rtl/sdcard_apb_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sd_pkg.sv
// Shared SD-card APB definitions: bus widths and the arbiter state encoding.
package sd_pkg;

   localparam int SD_APB_ADDR_W = 5;
   localparam int SD_APB_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      RESP   = 3'd3,
      HOLD   = 3'd4
   } sd_arb_state_t;

endpackage

// File: rtl/sdcard_apb_arbiter.sv
// Two-requester APB arbiter in front of the SD-card controller slave port.
// The downstream APB master is fully registered. A locked owner keeps the grant
// between transfers so that multi-register command sequences stay atomic; an
// optional idle limit stops a stalled owner from holding the port forever.
module sdcard_apb_arbiter
   import sd_pkg::*;
#(
   parameter int ADDR_W     = SD_APB_ADDR_W,
   parameter int DATA_W     = SD_APB_DATA_W,
   parameter int PRIO_FIXED = 0,
   parameter int LOCK_MAX   = 1024
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_psel,
   input  logic              m0_penable,
   input  logic              m0_pwrite,
   input  logic [ADDR_W-1:0] m0_paddr,
   input  logic [DATA_W-1:0] m0_pwdata,
   input  logic              m0_lock,
   output logic              m0_pready,
   output logic [DATA_W-1:0] m0_prdata,

   input  logic              m1_psel,
   input  logic              m1_penable,
   input  logic              m1_pwrite,
   input  logic [ADDR_W-1:0] m1_paddr,
   input  logic [DATA_W-1:0] m1_pwdata,
   input  logic              m1_lock,
   output logic              m1_pready,
   output logic [DATA_W-1:0] m1_prdata,

   output logic              s_psel,
   output logic              s_penable,
   output logic              s_pwrite,
   output logic [ADDR_W-1:0] s_paddr,
   output logic [DATA_W-1:0] s_pwdata,
   input  logic              s_pready,
   input  logic [DATA_W-1:0] s_prdata,

   output logic              owner
);

   // Last idle HOLD cycle before a locked grant is forcibly released.
   localparam logic [31:0] LOCK_LAST = 32'(LOCK_MAX - 1);

   sd_arb_state_t     state;
   logic              lat_lock;
   logic [31:0]       lock_cnt;

   logic              win;
   logic              src;
   logic              owner_psel;
   logic              owner_lock;
   logic              sel_write;
   logic              sel_lock;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Access-phase strobes carry nothing the arbiter needs: a request is psel
   // alone, and the request fields are sampled once at grant.
   logic unused_penable;
   assign unused_penable = m0_penable ^ m1_penable;

   // Tie-break: fixed priority favours m0, round-robin favours whoever did not
   // win last time. With a single requester that requester wins.
   always_comb begin
      win = 1'b0;
      if (m0_psel && m1_psel) begin
         win = (PRIO_FIXED != 0) ? 1'b0 : ~owner;
      end else if (m1_psel) begin
         win = 1'b1;
      end
   end

   // In HOLD only the current owner may start a transfer, so its fields are the
   // source; elsewhere the arbitration winner is.
   assign src        = (state == HOLD) ? owner : win;
   assign sel_write  = src ? m1_pwrite : m0_pwrite;
   assign sel_lock   = src ? m1_lock   : m0_lock;
   assign sel_addr   = src ? m1_paddr  : m0_paddr;
   assign sel_wdata  = src ? m1_pwdata : m0_pwdata;
   assign owner_psel = owner ? m1_psel : m0_psel;
   assign owner_lock = owner ? m1_lock : m0_lock;

   // Grant FSM, request latch, downstream APB master and lock hold counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= 1'b0;
         lat_lock  <= 1'b0;
         lock_cnt  <= '0;
         s_psel    <= 1'b0;
         s_penable <= 1'b0;
         s_pwrite  <= 1'b0;
         s_paddr   <= '0;
         s_pwdata  <= '0;
         m0_pready <= 1'b0;
         m1_pready <= 1'b0;
         m0_prdata <= '0;
         m1_prdata <= '0;
      end else begin
         // Ready is a single-cycle pulse; only the ACCESS exit raises it.
         m0_pready <= 1'b0;
         m1_pready <= 1'b0;

         case (state)
            IDLE: begin
               if (m0_psel || m1_psel) begin
                  owner     <= src;
                  s_pwrite  <= sel_write;
                  s_paddr   <= sel_addr;
                  s_pwdata  <= sel_wdata;
                  lat_lock  <= sel_lock;
                  s_psel    <= 1'b1;
                  s_penable <= 1'b0;
                  state     <= SETUP;
               end
            end

            SETUP: begin
               s_penable <= 1'b1;
               state     <= ACCESS;
            end

            ACCESS: begin
               // No timeout: the controller is trusted to finish eventually.
               if (s_pready) begin
                  s_psel    <= 1'b0;
                  s_penable <= 1'b0;
                  if (owner) begin
                     m1_pready <= 1'b1;
                     if (!s_pwrite) m1_prdata <= s_prdata;
                  end else begin
                     m0_pready <= 1'b1;
                     if (!s_pwrite) m0_prdata <= s_prdata;
                  end
                  state <= RESP;
               end
            end

            RESP: begin
               lock_cnt <= '0;
               state    <= lat_lock ? HOLD : IDLE;
            end

            HOLD: begin
               if (owner_psel) begin
                  // Next transfer of a locked sequence: no arbitration, and
                  // the lock request is taken afresh from this transfer.
                  s_pwrite  <= sel_write;
                  s_paddr   <= sel_addr;
                  s_pwdata  <= sel_wdata;
                  lat_lock  <= sel_lock;
                  s_psel    <= 1'b1;
                  s_penable <= 1'b0;
                  lock_cnt  <= '0;
                  state     <= SETUP;
               end else if (!owner_lock) begin
                  lock_cnt <= '0;
                  state    <= IDLE;
               end else if ((LOCK_MAX != 0) && (lock_cnt == LOCK_LAST)) begin
                  // Idle limit reached: release the grant; any waiting
                  // requester is arbitrated from IDLE on the next cycle.
                  lock_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  lock_cnt <= lock_cnt + 32'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
